// File: rtl/tower_build_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tower_build_ctrl
// Description : Validates build/sell commands for the tower slots, pulses the
//               addressed slot, confirms its is_used flag and owns player gold.
// Revision    : 1.0 - initial release
// ============================================================================
module tower_build_ctrl #(
    parameter int NUM_SLOTS  = 8,
    parameter int GOLD_W     = 12,
    parameter int START_GOLD = 400,
    parameter int COST1      = 100,
    parameter int COST2      = 150,
    parameter int COST3      = 200,
    localparam int SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   cmd_build,
    input  logic                   cmd_sell,
    input  logic [SW-1:0]          cmd_slot,
    input  logic [2:0]             cmd_type,
    input  logic [NUM_SLOTS-1:0]   slot_used,
    input  logic [3*NUM_SLOTS-1:0] slot_type,
    input  logic                   reward_valid,
    input  logic [7:0]             reward_amt,
    output logic [NUM_SLOTS-1:0]   build_en,
    output logic [NUM_SLOTS-1:0]   sell_en,
    output logic [2:0]             type_com,
    output logic [GOLD_W-1:0]      gold,
    output logic                   busy,
    output logic                   cmd_done,
    output logic                   cmd_err,
    output logic [1:0]             err_code
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_check   = 2'd1;
    localparam logic [1:0] c_st_issue   = 2'd2;
    localparam logic [1:0] c_st_confirm = 2'd3;

    localparam logic [1:0] c_err_type   = 2'd0;
    localparam logic [1:0] c_err_gold   = 2'd1;
    localparam logic [1:0] c_err_slot   = 2'd2;
    localparam logic [1:0] c_err_conf   = 2'd3;

    localparam logic [GOLD_W-1:0] c_cost1 = GOLD_W'(COST1);
    localparam logic [GOLD_W-1:0] c_cost2 = GOLD_W'(COST2);
    localparam logic [GOLD_W-1:0] c_cost3 = GOLD_W'(COST3);
    localparam logic [GOLD_W-1:0] c_start = GOLD_W'(START_GOLD);

    logic [1:0]        r_state;
    logic              r_op_build;
    logic [SW-1:0]     r_slot;
    logic [2:0]        r_type;
    logic [GOLD_W-1:0] r_amount;
    logic [GOLD_W-1:0] r_gold;
    logic              r_chk_err;
    logic [1:0]        r_chk_code;

    logic              w_slot_in_range;
    logic              w_used_sel;
    logic [2:0]        w_type_sel;
    logic [GOLD_W-1:0] w_build_cost;
    logic [GOLD_W-1:0] w_refund;
    logic              w_chk_err;
    logic [1:0]        w_chk_code;
    logic              w_issue;
    logic              w_confirm;
    logic              w_confirm_ok;
    logic              w_confirm_fail;
    logic [GOLD_W:0]   w_inc;
    logic [GOLD_W:0]   w_dec;
    logic [GOLD_W:0]   w_sum;
    logic [GOLD_W-1:0] w_gold_next;

    function automatic logic [GOLD_W-1:0] f_cost(input logic [2:0] t);
        case (t)
            3'd1:    f_cost = c_cost1;
            3'd2:    f_cost = c_cost2;
            3'd3:    f_cost = c_cost3;
            default: f_cost = '0;
        endcase
    endfunction

    // Slot lookups are masked when the latched index is beyond the slot count.
    assign w_slot_in_range = (32'(r_slot) < NUM_SLOTS);
    assign w_used_sel      = w_slot_in_range ? slot_used[r_slot] : 1'b0;
    assign w_type_sel      = w_slot_in_range ? slot_type[32'(r_slot)*3 +: 3] : 3'd0;
    assign w_build_cost    = f_cost(r_type);
    assign w_refund        = f_cost(w_type_sel) >> 1;

    always_comb begin
        w_chk_err  = 1'b0;
        w_chk_code = c_err_type;
        if (r_op_build && ((r_type == 3'd0) || (r_type > 3'd3))) begin
            w_chk_err  = 1'b1;
            w_chk_code = c_err_type;
        end else if (!w_slot_in_range || (r_op_build && w_used_sel) ||
                     (!r_op_build && !w_used_sel)) begin
            w_chk_err  = 1'b1;
            w_chk_code = c_err_slot;
        end else if (r_op_build && (w_build_cost > r_gold)) begin
            w_chk_err  = 1'b1;
            w_chk_code = c_err_gold;
        end
    end

    assign w_issue        = (r_state == c_st_issue);
    assign w_confirm      = (r_state == c_st_confirm);
    assign w_confirm_ok   = (w_used_sel == r_op_build);
    assign w_confirm_fail = w_confirm && !w_confirm_ok;

    // Reward, cost/refund and any reversal are folded into one saturating update.
    always_comb begin
        w_inc = reward_valid ? (GOLD_W+1)'(reward_amt) : '0;
        w_dec = '0;
        if (w_issue) begin
            if (r_op_build) begin
                w_dec = {1'b0, r_amount};
            end else begin
                w_inc = w_inc + {1'b0, r_amount};
            end
        end else if (w_confirm_fail) begin
            if (r_op_build) begin
                w_inc = w_inc + {1'b0, r_amount};
            end else begin
                w_dec = {1'b0, r_amount};
            end
        end
        w_sum       = {1'b0, r_gold} + w_inc - w_dec;
        w_gold_next = w_sum[GOLD_W] ? {GOLD_W{1'b1}} : w_sum[GOLD_W-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= c_st_idle;
            r_op_build <= 1'b0;
            r_slot     <= '0;
            r_type     <= 3'd0;
            r_amount   <= '0;
            r_gold     <= c_start;
            r_chk_err  <= 1'b0;
            r_chk_code <= 2'd0;
        end else begin
            r_gold    <= w_gold_next;
            r_chk_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (cmd_build || cmd_sell) begin
                        r_op_build <= cmd_build;
                        r_slot     <= cmd_slot;
                        r_type     <= cmd_type;
                        r_state    <= c_st_check;
                    end
                end
                c_st_check: begin
                    if (w_chk_err) begin
                        r_chk_err  <= 1'b1;
                        r_chk_code <= w_chk_code;
                        r_state    <= c_st_idle;
                    end else begin
                        r_amount <= r_op_build ? w_build_cost : w_refund;
                        r_state  <= c_st_issue;
                    end
                end
                c_st_issue:   r_state <= c_st_confirm;
                c_st_confirm: r_state <= c_st_idle;
                default:      r_state <= c_st_idle;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_dec
            assign build_en[gi] = w_issue &&  r_op_build && (r_slot == SW'(gi));
            assign sell_en[gi]  = w_issue && !r_op_build && (r_slot == SW'(gi));
        end
    endgenerate

    assign type_com = (w_issue && r_op_build) ? r_type : 3'd0;
    assign gold     = r_gold;
    assign busy     = (r_state != c_st_idle);
    assign cmd_done = w_confirm && w_confirm_ok;
    assign cmd_err  = r_chk_err || w_confirm_fail;
    assign err_code = r_chk_err      ? r_chk_code :
                      w_confirm_fail ? c_err_conf : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_tower_build_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tower_build_ctrl
// Description : Self-checking bench for tower_build_ctrl with a slot model and
//               a transaction-level gold/error reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tower_build_ctrl;

    localparam int NS   = 8;
    localparam int GMAX = 4095;

    logic        Clk;
    logic        Reset;
    logic        cmd_build;
    logic        cmd_sell;
    logic [2:0]  cmd_slot;
    logic [2:0]  cmd_type;
    logic [7:0]  phys_used;
    logic [23:0] phys_type;
    logic        reward_valid;
    logic [7:0]  reward_amt;
    logic [7:0]  build_en;
    logic [7:0]  sell_en;
    logic [2:0]  type_com;
    logic [11:0] gold;
    logic        busy;
    logic        cmd_done;
    logic        cmd_err;
    logic [1:0]  err_code;

    int n_checks;
    int n_fail;

    logic [7:0]  ob_ben  [0:4];
    logic [7:0]  ob_sen  [0:4];
    logic [2:0]  ob_tc   [0:4];
    logic [11:0] ob_gold [0:4];
    logic        ob_busy [0:4];
    logic        ob_done [0:4];
    logic        ob_err  [0:4];
    logic [1:0]  ob_code [0:4];
    logic [35:0] ob_vec  [0:4];
    logic        rw_en   [0:3];
    logic [7:0]  rw_amt  [0:3];

    tower_build_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .cmd_build    (cmd_build),
        .cmd_sell     (cmd_sell),
        .cmd_slot     (cmd_slot),
        .cmd_type     (cmd_type),
        .slot_used    (phys_used),
        .slot_type    (phys_type),
        .reward_valid (reward_valid),
        .reward_amt   (reward_amt),
        .build_en     (build_en),
        .sell_en      (sell_en),
        .type_com     (type_com),
        .gold         (gold),
        .busy         (busy),
        .cmd_done     (cmd_done),
        .cmd_err      (cmd_err),
        .err_code     (err_code)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1);
    end

    function automatic int tb_cost(input int t);
        return (t == 1) ? 100 : (t == 2) ? 150 : (t == 3) ? 200 : 0;
    endfunction

    function automatic int sat(input int x);
        return (x > GMAX) ? GMAX : x;
    endfunction

    task automatic clear_rw;
        for (int c = 0; c < 4; c++) begin
            rw_en[c]  = 1'b0;
            rw_amt[c] = 8'd0;
        end
    endtask

    task automatic do_reset;
        Reset        = 1'b1;
        cmd_build    = 1'b0;
        cmd_sell     = 1'b0;
        cmd_slot     = 3'd0;
        cmd_type     = 3'd0;
        reward_valid = 1'b0;
        reward_amt   = 8'd0;
        phys_used    = '0;
        phys_type    = '0;
        clear_rw();
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    task automatic sample(input int c);
        ob_ben[c]  = build_en;
        ob_sen[c]  = sell_en;
        ob_tc[c]   = type_com;
        ob_gold[c] = gold;
        ob_busy[c] = busy;
        ob_done[c] = cmd_done;
        ob_err[c]  = cmd_err;
        ob_code[c] = cmd_err ? err_code : 2'd0;
        ob_vec[c]  = {busy, cmd_done, cmd_err, ob_code[c], build_en, sell_en, type_com, gold};
    endtask

    // Drives one command from cycle 0 and records outputs for cycles 0..4.
    // Cooperating slots react to their enable pulse like real tower instances.
    task automatic run_cmd(input logic b, input logic s, input logic [2:0] sl,
                           input logic [2:0] ty, input bit coop, input bit resend);
        cmd_build    = b;
        cmd_sell     = s;
        cmd_slot     = sl;
        cmd_type     = ty;
        reward_valid = rw_en[0];
        reward_amt   = rw_amt[0];
        sample(0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge Clk); #1;
            cmd_sell  = 1'b0;
            cmd_build = resend && (c < 4);
            if (resend) begin
                cmd_slot = 3'd7;
                cmd_type = 3'd1;
            end
            if (c < 4) begin
                reward_valid = rw_en[c];
                reward_amt   = rw_amt[c];
            end else begin
                reward_valid = 1'b0;
                reward_amt   = 8'd0;
            end
            sample(c);
            if (coop) begin
                for (int i = 0; i < NS; i++) begin
                    if (build_en[i]) begin
                        phys_used[i]         = 1'b1;
                        phys_type[i*3 +: 3] = type_com;
                    end
                    if (sell_en[i]) begin
                        phys_used[i]         = 1'b0;
                        phys_type[i*3 +: 3] = 3'd0;
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if (gold !== 12'd400) begin
            n_fail++; $display("FAIL reset_gold: got %0d expected 400", gold);
        end
        n_checks++;
        if ({busy, cmd_done, cmd_err, build_en, sell_en, type_com} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, cmd_done, cmd_err, build_en, sell_en, type_com});
        end
    endtask

    task automatic test_build;
        do_reset();
        run_cmd(1'b1, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0);
        n_checks++;
        if (ob_ben[2] !== 8'h08 || ob_tc[2] !== 3'd2) begin
            n_fail++; $display("FAIL build_pulse: got en=%h type=%0d expected en=08 type=2", ob_ben[2], ob_tc[2]);
        end
        n_checks++;
        if ((ob_ben[1] | ob_ben[3] | ob_ben[4]) !== 8'h00 || ob_tc[3] !== 3'd0) begin
            n_fail++; $display("FAIL build_pulse_width: got en=%h type3=%0d expected 0", ob_ben[1] | ob_ben[3] | ob_ben[4], ob_tc[3]);
        end
        n_checks++;
        if (ob_gold[2] !== 12'd400 || ob_gold[3] !== 12'd250) begin
            n_fail++; $display("FAIL build_gold: got c2=%0d c3=%0d expected 400 250", ob_gold[2], ob_gold[3]);
        end
        n_checks++;
        if ({ob_done[2], ob_done[3], ob_err[3]} !== 3'b010) begin
            n_fail++; $display("FAIL build_done: got %b expected 010", {ob_done[2], ob_done[3], ob_err[3]});
        end
        n_checks++;
        if ({ob_busy[0], ob_busy[1], ob_busy[2], ob_busy[3], ob_busy[4]} !== 5'b01110) begin
            n_fail++; $display("FAIL build_busy: got %b expected 01110", {ob_busy[0], ob_busy[1], ob_busy[2], ob_busy[3], ob_busy[4]});
        end
    endtask

    task automatic test_sell;
        do_reset();
        run_cmd(1'b1, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0);
        run_cmd(1'b0, 1'b1, 3'd3, 3'd0, 1'b1, 1'b0);
        n_checks++;
        if (ob_sen[2] !== 8'h08 || ob_ben[2] !== 8'h00 || ob_tc[2] !== 3'd0) begin
            n_fail++; $display("FAIL sell_pulse: got sen=%h ben=%h type=%0d expected 08 00 0", ob_sen[2], ob_ben[2], ob_tc[2]);
        end
        n_checks++;
        if (ob_gold[3] !== 12'd325 || ob_done[3] !== 1'b1) begin
            n_fail++; $display("FAIL sell_refund: got gold=%0d done=%b expected 325 1", ob_gold[3], ob_done[3]);
        end
        run_cmd(1'b0, 1'b1, 3'd5, 3'd0, 1'b1, 1'b0);
        n_checks++;
        if (ob_err[2] !== 1'b1 || ob_code[2] !== 2'd2 || ob_sen[2] !== 8'h00 || ob_gold[4] !== 12'd325) begin
            n_fail++; $display("FAIL sell_empty: got err=%b code=%0d sen=%h gold=%0d expected 1 2 00 325", ob_err[2], ob_code[2], ob_sen[2], ob_gold[4]);
        end
    endtask

    task automatic test_errors;
        logic [2:0] bad_ty   [0:3];
        logic [2:0] bad_sl   [0:3];
        logic [1:0] bad_code [0:3];
        do_reset();
        run_cmd(1'b1, 1'b0, 3'd1, 3'd2, 1'b1, 1'b0);
        run_cmd(1'b1, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0);
        phys_used[5]      = 1'b1;
        phys_type[15 +: 3] = 3'd1;
        bad_ty[0] = 3'd3; bad_sl[0] = 3'd4; bad_code[0] = 2'd1;
        bad_ty[1] = 3'd0; bad_sl[1] = 3'd4; bad_code[1] = 2'd0;
        bad_ty[2] = 3'd4; bad_sl[2] = 3'd4; bad_code[2] = 2'd0;
        bad_ty[3] = 3'd1; bad_sl[3] = 3'd5; bad_code[3] = 2'd2;
        for (int k = 0; k < 4; k++) begin
            run_cmd(1'b1, 1'b0, bad_sl[k], bad_ty[k], 1'b1, 1'b0);
            n_checks++;
            if (ob_err[2] !== 1'b1 || ob_code[2] !== bad_code[k] || ob_err[1] !== 1'b0 || ob_busy[2] !== 1'b0) begin
                n_fail++; $display("FAIL err_case%0d: got err=%b code=%0d expected 1 %0d", k, ob_err[2], ob_code[2], bad_code[k]);
            end
            n_checks++;
            if ((ob_ben[1] | ob_ben[2] | ob_ben[3]) !== 8'h00 || ob_gold[4] !== 12'd150 || ob_done[3] !== 1'b0) begin
                n_fail++; $display("FAIL err_side%0d: got en=%h gold=%0d done=%b expected 00 150 0", k, ob_ben[2], ob_gold[4], ob_done[3]);
            end
        end
        // Cost equal to gold is affordable.
        run_cmd(1'b1, 1'b0, 3'd6, 3'd2, 1'b1, 1'b0);
        n_checks++;
        if (ob_done[3] !== 1'b1 || ob_gold[3] !== 12'd0) begin
            n_fail++; $display("FAIL exact_cost: got done=%b gold=%0d expected 1 0", ob_done[3], ob_gold[3]);
        end
    endtask

    task automatic test_reward_sat;
        do_reset();
        rw_en[2] = 1'b1; rw_amt[2] = 8'd50;
        run_cmd(1'b1, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0);
        clear_rw();
        n_checks++;
        if (ob_gold[3] !== 12'd350) begin
            n_fail++; $display("FAIL reward_net: got %0d expected 350", ob_gold[3]);
        end
        reward_valid = 1'b1; reward_amt = 8'd255;
        for (int k = 0; k < 14; k++) begin
            @(posedge Clk); #1;
        end
        reward_amt = 8'd80;
        @(posedge Clk); #1;
        reward_valid = 1'b0;
        n_checks++;
        if (gold !== 12'd4000) begin
            n_fail++; $display("FAIL reward_accum: got %0d expected 4000", gold);
        end
        reward_valid = 1'b1; reward_amt = 8'd255;
        @(posedge Clk); #1;
        reward_valid = 1'b0;
        n_checks++;
        if (gold !== 12'd4095) begin
            n_fail++; $display("FAIL reward_sat: got %0d expected 4095", gold);
        end
        rw_en[2] = 1'b1; rw_amt[2] = 8'd255;
        run_cmd(1'b1, 1'b0, 3'd1, 3'd1, 1'b1, 1'b0);
        clear_rw();
        n_checks++;
        if (ob_gold[3] !== 12'd4095 || ob_done[3] !== 1'b1) begin
            n_fail++; $display("FAIL sat_with_cost: got gold=%0d done=%b expected 4095 1", ob_gold[3], ob_done[3]);
        end
    endtask

    task automatic test_confirm_fail;
        do_reset();
        run_cmd(1'b1, 1'b0, 3'd3, 3'd1, 1'b0, 1'b0);
        n_checks++;
        if (ob_ben[2] !== 8'h08 || ob_err[3] !== 1'b1 || ob_code[3] !== 2'd3 || ob_done[3] !== 1'b0) begin
            n_fail++; $display("FAIL confirm_err: got en=%h err=%b code=%0d done=%b expected 08 1 3 0", ob_ben[2], ob_err[3], ob_code[3], ob_done[3]);
        end
        n_checks++;
        if (ob_gold[3] !== 12'd300 || ob_gold[4] !== 12'd400 || ob_err[4] !== 1'b0) begin
            n_fail++; $display("FAIL confirm_revert: got c3=%0d c4=%0d err4=%b expected 300 400 0", ob_gold[3], ob_gold[4], ob_err[4]);
        end
    endtask

    task automatic test_reset_midflight;
        logic seen;
        for (int stage = 1; stage <= 2; stage++) begin
            do_reset();
            cmd_build = 1'b1; cmd_slot = 3'd4; cmd_type = 3'd1;
            @(posedge Clk); #1;
            cmd_build = 1'b0;
            if (stage == 2) begin
                @(posedge Clk); #1;
                n_checks++;
                if (build_en !== 8'h10) begin
                    n_fail++; $display("FAIL midflight_issue: got %h expected 10", build_en);
                end
            end
            Reset = 1'b1; reward_valid = 1'b1; reward_amt = 8'd50;
            @(posedge Clk); #1;
            Reset = 1'b0; reward_valid = 1'b0; reward_amt = 8'd0;
            n_checks++;
            if ({busy, cmd_done, cmd_err, build_en, sell_en, type_com, gold} !== {22'd0, 12'd400}) begin
                n_fail++; $display("FAIL midflight_reset%0d: got %h expected %h", stage,
                                   {busy, cmd_done, cmd_err, build_en, sell_en, type_com, gold}, {22'd0, 12'd400});
            end
            seen = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(posedge Clk); #1;
                seen = seen | busy | cmd_done | cmd_err | (|build_en) | (|sell_en) | (gold != 12'd400);
            end
            n_checks++;
            if (seen !== 1'b0) begin
                n_fail++; $display("FAIL midflight_after%0d: got activity=1 expected 0", stage);
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic seen;
        do_reset();
        run_cmd(1'b1, 1'b0, 3'd6, 3'd1, 1'b1, 1'b1);
        n_checks++;
        if (ob_ben[2] !== 8'h40 || (ob_ben[1] | ob_ben[3] | ob_ben[4]) !== 8'h00 || ob_done[3] !== 1'b1 || ob_gold[3] !== 12'd300) begin
            n_fail++; $display("FAIL busy_first: got en=%h done=%b gold=%0d expected 40 1 300", ob_ben[2], ob_done[3], ob_gold[3]);
        end
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            seen = seen | busy | (|build_en) | cmd_done | cmd_err;
        end
        n_checks++;
        if (seen !== 1'b0 || phys_used !== 8'h40) begin
            n_fail++; $display("FAIL busy_dropped: got activity=%b used=%h expected 0 40", seen, phys_used);
        end
    endtask

    task automatic test_random;
        int          g0, g1, g2, g3, g4, amt, code, mgold;
        int          rw [0:3];
        bit          b, s, ok, coop;
        logic [2:0]  sl, ty;
        logic [7:0]  pulse;
        logic [35:0] ev [0:4];
        do_reset();
        mgold = 400;
        for (int it = 0; it < 60; it++) begin
            if (it % 20 == 19) begin
                do_reset();
                mgold = 400;
            end
            b    = 1'($urandom_range(0, 1));
            s    = b ? 1'($urandom_range(0, 1)) : 1'b1;
            sl   = 3'($urandom_range(0, 7));
            ty   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
            coop = ($urandom_range(0, 4) != 0);
            for (int c = 0; c < 4; c++) begin
                rw_en[c]  = ($urandom_range(0, 3) == 0);
                rw_amt[c] = 8'($urandom_range(0, 63));
                rw[c]     = rw_en[c] ? int'(rw_amt[c]) : 0;
            end
            g0 = mgold;
            g1 = sat(g0 + rw[0]);
            code = -1;
            if (b && (ty == 3'd0 || ty > 3'd3))                 code = 0;
            else if (b ? phys_used[sl] : !phys_used[sl])      code = 2;
            else if (b && tb_cost(int'(ty)) > g1)               code = 1;
            ok  = (code < 0);
            amt = b ? tb_cost(int'(ty)) : tb_cost(int'(phys_type[int'(sl)*3 +: 3])) / 2;
            g2  = sat(g1 + rw[1]);
            g3  = sat(g2 + rw[2] + (ok ? (b ? -amt : amt) : 0));
            g4  = sat(g3 + rw[3] + ((ok && !coop) ? (b ? amt : -amt) : 0));
            pulse = 8'd1 << sl;
            ev[0] = {5'd0, 19'd0, 12'(g0)};
            ev[1] = {1'b1, 4'd0, 19'd0, 12'(g1)};
            ev[2] = ok ? {1'b1, 4'd0, (b ? pulse : 8'd0), (b ? 8'd0 : pulse), (b ? ty : 3'd0), 12'(g2)}
                       : {3'b001, 2'(code), 19'd0, 12'(g2)};
            ev[3] = ok ? {1'b1, coop, !coop, (coop ? 2'd0 : 2'd3), 19'd0, 12'(g3)}
                       : {5'd0, 19'd0, 12'(g3)};
            ev[4] = {5'd0, 19'd0, 12'(g4)};
            run_cmd(b, s, sl, ty, coop, 1'b0);
            for (int c = 0; c <= 4; c++) begin
                n_checks++;
                if (ob_vec[c] !== ev[c]) begin
                    n_fail++;
                    $display("FAIL rand it%0d c%0d (b=%0d sl=%0d ty=%0d coop=%0d): got %h expected %h",
                             it, c, b, sl, ty, coop, ob_vec[c], ev[c]);
                end
            end
            mgold = g4;
        end
        clear_rw();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset        = 1'b1;
        cmd_build    = 1'b0;
        cmd_sell     = 1'b0;
        cmd_slot     = 3'd0;
        cmd_type     = 3'd0;
        reward_valid = 1'b0;
        reward_amt   = 8'd0;
        phys_used    = '0;
        phys_type    = '0;
        clear_rw();
        test_reset();
        test_build();
        test_sell();
        test_errors();
        test_reward_sat();
        test_confirm_fail();
        test_reset_midflight();
        test_busy_ignore();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tower_build_ctrl.md
Name: tower_build_ctrl

Overview:
Command controller directly upstream of the per-slot tower instances. It accepts build and sell requests, validates them against tower type, slot occupancy and the gold balance, and issues one-cycle enable/sell pulses plus type_com to the addressed slot. It then confirms that the slot's is_used flag changed. It owns the player gold register, including kill-reward crediting.

Parameters:
NUM_SLOTS, 8, number of tower slots; slot index width SW = clog2(NUM_SLOTS)
GOLD_W, 12, gold register width
START_GOLD, 400, gold value after reset
COST1, 100, build cost of tower type 1
COST2, 150, build cost of tower type 2
COST3, 200, build cost of tower type 3

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
cmd_build  in  1  build request, sampled only in IDLE
cmd_sell  in  1  sell request, sampled only in IDLE
cmd_slot  in  SW  target slot index
cmd_type  in  3  tower type for a build (valid values 1..3)
slot_used  in  NUM_SLOTS  is_used flag from each slot
slot_type  in  3*NUM_SLOTS  occur_type from each slot; slot i occupies bits [3i+2:3i]
reward_valid  in  1  credit reward_amt this cycle
reward_amt  in  8  kill bounty
build_en  out  NUM_SLOTS  one-hot build pulse, drives each slot's enable
sell_en  out  NUM_SLOTS  one-hot sell pulse, drives each slot's sell
type_com  out  3  type presented to the slots
gold  out  GOLD_W  current gold
busy  out  1  high in every state except IDLE
cmd_done  out  1  one-cycle success pulse
cmd_err  out  1  one-cycle failure pulse
err_code  out  2  failure cause, valid only when cmd_err=1

Behaviour:
- Reset (synchronous, highest priority, allowed in any state):
  - state goes to IDLE, gold = START_GOLD, latched command cleared.
  - All outputs 0 except gold; type_com = 0.
  - An in-flight command is discarded: no pulse, no gold change, no done/err.
- State sequence: IDLE, CHECK, ISSUE, CONFIRM, with cycle numbering relative to acceptance:
  - Cycle 0, IDLE: if cmd_build or cmd_sell is high, latch op, slot and type, then go to CHECK.
    - cmd_build has priority when both are high.
    - Commands arriving outside IDLE are dropped silently.
  - Cycle 1, CHECK: evaluate errors, first match wins:
    - code 0: build with type 0 or type >3.
    - code 2: slot index >= NUM_SLOTS; build to an occupied slot; sell of an empty slot.
    - code 1: build cost > gold.
    - On an error, the next state is IDLE and cmd_err=1 with err_code registered, visible in cycle 2.
    - Otherwise go to ISSUE. For a sell, latch refund = cost(slot_type[slot]) >> 1.
  - Cycle 2, ISSUE:
    - build: build_en[slot]=1 and type_com=latched type.
    - sell: sell_en[slot]=1 and type_com=0.
    - Exactly one bit is high across both vectors, for one cycle.
    - Gold is updated on the closing edge (−cost for a build, +refund for a sell) and is visible in cycle 3. Then go to CONFIRM.
  - Cycle 3, CONFIRM: check slot_used[slot].
    - Expected value is 1 after a build, 0 after a sell.
    - Match: cmd_done=1.
    - Mismatch: cmd_err=1, err_code=3, and the gold change is reversed (visible in cycle 4).
    - Go to IDLE in both cases.
- Control outputs are decoded from state, so cmd_done, cmd_err, build_en and sell_en are never high for more than one cycle.
- Gold arithmetic:
  - Compute at GOLD_W+1 bits, then saturate at 2^GOLD_W−1.
  - reward_valid credits in any state.
  - When a reward coincides with a cost, refund or reversal in the same cycle, the net sum is applied once.
  - Underflow is impossible: rewards only add between CHECK and ISSUE.
- type_com holds 0 outside ISSUE.

Test Plan:
1. Reset, then cmd_build with slot 3, type 2; bench drives slot_used[3]=1 from cycle 3 -> build_en=8'b0000_1000 and type_com=2 in cycle 2 only; gold 400->250 in cycle 3; cmd_done in cycle 3; busy high for cycles 1-3.
2. Gold=150, cmd_build with type 3 -> cmd_err=1 with err_code=1 in cycle 2; build_en never asserts; gold stays 150. Repeat with type 0 -> err_code=0; repeat with slot_used[5]=1 and a build to slot 5 -> err_code=2.
3. Slot 3 holding type 2, cmd_sell for slot 3; bench clears slot_used[3] in cycle 3 -> sell_en[3] in cycle 2; gold 250->325; cmd_done in cycle 3. A sell to an empty slot -> err_code=2.
4. Gold=400, build of type 1 with reward_valid=1 and reward_amt=50 in the ISSUE cycle -> gold=350 in cycle 3. With GOLD_W=12, gold=4000 and reward 255 -> gold saturates at 4095.
5. Build to slot 3 while the bench holds slot_used[3]=0 -> cmd_err=1 with err_code=3 in cycle 3; gold drops 400->300 and is restored to 400 in cycle 4.
6. Reset asserted in CHECK, then separately in ISSUE -> the following cycle shows IDLE, gold=400, all outputs low, no done or err. Also: cmd_build pulsed while busy is ignored, with no extra pulse afterwards.
